// File: rtl/alu_div_sequencer.sv
// Multicycle unsigned restoring divider that sequences a shared combinational ALU.
// The ALU operand/control outputs are registered one cycle ahead, so during each
// state they already hold the drive that state needs, and the ALU answer is
// consumed in the same cycle.
`timescale 1ns/1ps

module alu_div_sequencer #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             Clock,
   input  logic             ResetN,
   input  logic             Start,
   output logic             Ready,
   input  logic [WIDTH-1:0] Dividend,
   input  logic [WIDTH-1:0] Divisor,
   output logic             ResultValid,
   input  logic             ResultReady,
   output logic [WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0] Remainder,
   output logic             DivByZero,
   output logic [WIDTH-1:0] AluA,
   output logic [WIDTH-1:0] AluB,
   output logic             AluAInvert,
   output logic             AluBNegate,
   output logic [1:0]       AluOp,
   input  logic [WIDTH-1:0] AluResult,
   input  logic             AluZero,
   input  logic             AluCarryOut,
   input  logic             AluOverflow
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_ADD = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CHECK,
      S_ITER,
      S_DONE
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   dvs_q;      // latched divisor
   logic [WIDTH-1:0]   rem_q;      // partial remainder R
   logic [WIDTH-1:0]   quo_q;      // dividend bits shifting out / quotient bits shifting in
   logic [CNT_W-1:0]   cnt_q;      // remaining iteration steps minus one

   logic [WIDTH-1:0]   shifted;
   logic               take;
   logic [WIDTH-1:0]   rem_next;
   logic [WIDTH-1:0]   quo_next;
   logic [WIDTH-1:0]   shifted_next;
   logic               unused_ok;

   // The ALU is only ever used for OR and subtract here; invert of A is never needed.
   assign AluAInvert = 1'b0;

   // Overflow has no meaning for an unsigned compare-by-subtract.
   assign unused_ok = AluOverflow;

   // One restoring step: shift in next dividend bit, keep the difference when it did not borrow.
   // A set MSB in R means the shifted value is >= 2^WIDTH > V, so the subtract must be taken;
   // the WIDTH-bit modulo difference is then still the exact remainder.
   always_comb begin
      shifted      = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
      take         = rem_q[WIDTH-1] | AluCarryOut;
      rem_next     = take ? AluResult : shifted;
      quo_next     = {quo_q[WIDTH-2:0], take};
      shifted_next = {rem_next[WIDTH-2:0], quo_next[WIDTH-1]};
   end

   // Control FSM, datapath registers and pre-registered ALU drive.
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state       <= S_IDLE;
         Ready       <= 1'b1;
         ResultValid <= 1'b0;
         Quotient    <= '0;
         Remainder   <= '0;
         DivByZero   <= 1'b0;
         AluA        <= '0;
         AluB        <= '0;
         AluBNegate  <= 1'b0;
         AluOp       <= OP_AND;
         dvs_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         cnt_q       <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (Start) begin
                  dvs_q      <= Divisor;
                  rem_q      <= '0;
                  quo_q      <= Dividend;
                  cnt_q      <= CNT_W'(WIDTH - 1);
                  Ready      <= 1'b0;
                  // Zero test of the divisor: V | 0
                  AluA       <= Divisor;
                  AluB       <= '0;
                  AluOp      <= OP_OR;
                  AluBNegate <= 1'b0;
                  state      <= S_CHECK;
               end
            end

            S_CHECK: begin
               if (AluZero) begin
                  // quo_q still holds the untouched dividend here
                  Quotient    <= '1;
                  Remainder   <= quo_q;
                  DivByZero   <= 1'b1;
                  ResultValid <= 1'b1;
                  AluA        <= '0;
                  AluB        <= '0;
                  AluOp       <= OP_AND;
                  AluBNegate  <= 1'b0;
                  state       <= S_DONE;
               end else begin
                  AluA       <= shifted;
                  AluB       <= dvs_q;
                  AluOp      <= OP_ADD;
                  AluBNegate <= 1'b1;
                  state      <= S_ITER;
               end
            end

            S_ITER: begin
               rem_q <= rem_next;
               quo_q <= quo_next;
               if (cnt_q == '0) begin
                  Quotient    <= quo_next;
                  Remainder   <= rem_next;
                  DivByZero   <= 1'b0;
                  ResultValid <= 1'b1;
                  AluA        <= '0;
                  AluB        <= '0;
                  AluOp       <= OP_AND;
                  AluBNegate  <= 1'b0;
                  state       <= S_DONE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
                  AluA  <= shifted_next;
               end
            end

            S_DONE: begin
               if (ResultReady) begin
                  ResultValid <= 1'b0;
                  Ready       <= 1'b1;
                  state       <= S_IDLE;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_div_sequencer.sv
// Bench for alu_div_sequencer: behavioural 32-bit ALU plus a division reference model.
`timescale 1ns/1ps

module tb_alu_div_sequencer;

   localparam int unsigned WIDTH    = 32;
   localparam int          NORM_LAT = WIDTH + 2;
   localparam int          DBZ_LAT  = 2;
   localparam int          MAX_WAIT = 200;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic              ready;
   logic [WIDTH-1:0]  dividend;
   logic [WIDTH-1:0]  divisor;
   logic              result_valid;
   logic              result_ready;
   logic [WIDTH-1:0]  quotient;
   logic [WIDTH-1:0]  remainder;
   logic              div_by_zero;
   logic [WIDTH-1:0]  alu_a;
   logic [WIDTH-1:0]  alu_b;
   logic              alu_a_invert;
   logic              alu_b_negate;
   logic [1:0]        alu_op;
   logic [WIDTH-1:0]  alu_result;
   logic              alu_zero;
   logic              alu_carry;
   logic              alu_overflow;

   int n_vec;
   int n_err;

   alu_div_sequencer #(.WIDTH(WIDTH)) dut (
      .Clock       (clk),
      .ResetN      (rst_n),
      .Start       (start),
      .Ready       (ready),
      .Dividend    (dividend),
      .Divisor     (divisor),
      .ResultValid (result_valid),
      .ResultReady (result_ready),
      .Quotient    (quotient),
      .Remainder   (remainder),
      .DivByZero   (div_by_zero),
      .AluA        (alu_a),
      .AluB        (alu_b),
      .AluAInvert  (alu_a_invert),
      .AluBNegate  (alu_b_negate),
      .AluOp       (alu_op),
      .AluResult   (alu_result),
      .AluZero     (alu_zero),
      .AluCarryOut (alu_carry),
      .AluOverflow (alu_overflow)
   );

   // Behavioural model of the shared combinational 32-bit ALU.
   logic [WIDTH-1:0] aa, bb;
   logic [WIDTH:0]   sum;
   always_comb begin
      aa           = alu_a_invert ? ~alu_a : alu_a;
      bb           = alu_b_negate ? ~alu_b : alu_b;
      sum          = {1'b0, aa} + {1'b0, bb} + (WIDTH+1)'(alu_b_negate);
      alu_overflow = (aa[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != aa[WIDTH-1]);
      alu_carry    = sum[WIDTH];
      case (alu_op)
         2'b00:   alu_result = aa & bb;
         2'b01:   alu_result = aa | bb;
         2'b10:   alu_result = sum[WIDTH-1:0];
         default: alu_result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ alu_overflow};
      endcase
      alu_zero = (alu_result == '0);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      check($sformatf("%s.ready", tag), 64'(ready), 64'd1);
      check($sformatf("%s.valid", tag), 64'(result_valid), 64'd0);
      check($sformatf("%s.quo", tag), 64'(quotient), 64'd0);
      check($sformatf("%s.rem", tag), 64'(remainder), 64'd0);
      check($sformatf("%s.dbz", tag), 64'(div_by_zero), 64'd0);
      check($sformatf("%s.alu_ab", tag), {alu_a, alu_b}, 64'd0);
      check($sformatf("%s.alu_ctl", tag), 64'({alu_op, alu_b_negate, alu_a_invert}), 64'd0);
   endtask

   // One division transaction; hold > 0 keeps ResultReady low that many cycles with a stray Start.
   task automatic run_div(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input bit early_ready, input int hold);
      logic [WIDTH-1:0] exp_q, exp_r;
      int               exp_lat;
      int               lat;

      if (b == '0) begin
         exp_q   = '1;
         exp_r   = a;
         exp_lat = DBZ_LAT;
      end else begin
         exp_q   = a / b;
         exp_r   = a % b;
         exp_lat = NORM_LAT;
      end

      lat = 0;
      while (!ready && lat < MAX_WAIT) begin
         tick();
         lat++;
      end
      check($sformatf("%s.ready_in", tag), 64'(ready), 64'd1);

      dividend     = a;
      divisor      = b;
      start        = 1'b1;
      result_ready = early_ready;
      tick();
      start    = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;

      lat = 1;
      while (!result_valid && lat < MAX_WAIT) begin
         if (lat == 1) begin
            check($sformatf("%s.chk_ctl", tag), 64'({alu_op, alu_b_negate, alu_a_invert}),
                  64'({2'b01, 1'b0, 1'b0}));
            check($sformatf("%s.chk_ab", tag), {alu_a, alu_b}, {b, 32'h0});
         end
         if (lat == 2 && b != '0) begin
            check($sformatf("%s.it_ctl", tag), 64'({alu_op, alu_b_negate, alu_a_invert}),
                  64'({2'b10, 1'b1, 1'b0}));
            check($sformatf("%s.it_ab", tag), {alu_a, alu_b}, {{31'h0, a[WIDTH-1]}, b});
         end
         tick();
         lat++;
      end
      check($sformatf("%s.lat", tag), 64'(lat), 64'(exp_lat));
      check($sformatf("%s.quo", tag), 64'(quotient), 64'(exp_q));
      check($sformatf("%s.rem", tag), 64'(remainder), 64'(exp_r));
      check($sformatf("%s.dbz", tag), 64'(div_by_zero), 64'(b == '0));

      for (int i = 0; i < hold; i++) begin
         if (i == hold / 2) begin
            start    = 1'b1;
            dividend = 32'd77;
            divisor  = 32'd5;
         end
         tick();
         start = 1'b0;
         check($sformatf("%s.hold_rdy_valid", tag), 64'({ready, result_valid}), 64'b01);
         check($sformatf("%s.hold_qr", tag), {quotient, remainder}, {exp_q, exp_r});
      end

      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      check($sformatf("%s.hs", tag), 64'({ready, result_valid}), 64'b10);
      if (hold > 0) begin
         tick();
         tick();
         check($sformatf("%s.post_idle", tag), 64'({ready, result_valid}), 64'b10);
         check($sformatf("%s.post_qr", tag), {quotient, remainder}, {exp_q, exp_r});
      end
   endtask

   initial begin
      logic [WIDTH-1:0] ra, rb;
      int               mode;
      int               lat;

      n_vec        = 0;
      n_err        = 0;
      rst_n        = 1'b0;
      start        = 1'b0;
      dividend     = '0;
      divisor      = '0;
      result_ready = 1'b0;

      tick();
      tick();
      check_reset_state("reset");
      rst_n = 1'b1;
      tick();

      run_div("t1_100_7", 32'd100, 32'd7, 1'b0, 0);
      run_div("t2_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 0);
      run_div("t3a", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
      run_div("t3b", 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 0);
      run_div("t4_dbz", 32'd5, 32'd0, 1'b0, 0);
      run_div("t5_bp", 32'd1234567, 32'd89, 1'b0, 10);
      run_div("t5_bp_dbz", 32'd42, 32'd0, 1'b0, 10);

      // Abort 1000/3 at ITER step 10 with an asynchronous reset.
      dividend = 32'd1000;
      divisor  = 32'd3;
      start    = 1'b1;
      tick();
      start = 1'b0;
      lat   = 1;
      while (lat < 11) begin
         tick();
         lat++;
      end
      check("abort.busy", 64'({ready, result_valid}), 64'b00);
      rst_n = 1'b0;
      #1;
      check_reset_state("abort");
      tick();
      rst_n = 1'b1;
      tick();
      check("abort.no_result", 64'({ready, result_valid}), 64'b10);
      run_div("t6_1000_3", 32'd1000, 32'd3, 1'b0, 0);

      for (int n = 0; n < 2000; n++) begin
         mode = int'($urandom_range(0, 7));
         ra   = $urandom;
         rb   = $urandom;
         case (mode)
            0: rb = '0;
            1: rb = 32'($urandom_range(1, 15));
            2: ra = 32'($urandom_range(0, 1000));
            3: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            4: rb = rb >> $urandom_range(0, 31);
            default: ;
         endcase
         run_div($sformatf("rnd%0d", n), ra, rb, 1'($urandom_range(0, 1)), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
